p2_guesser: RTL and testbench
=============================

Name: p2_guesser

Overview:
Reverse-role companion of the number-guessing game: the player holds a secret number 0..MAX_VAL and the board guesses it by binary search. Each guess and the guess count are shown on the four seven-segment displays. The player answers each guess with push buttons (too high / too low / correct). The block detects inconsistent answers ("cheating") and ends in a win or error display. It sits at board top level alongside the existing bcdSevenSegment and binaryToBCD blocks.

Parameters:
MAX_VAL, 99, upper bound of secret range (lower bound fixed 0); must be <=99 for 2-digit display
BLINK_DIV, 25000000, clk50M cycles per blink half-period in WIN state (set to 4 in simulation)

Ports:
clk50M  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high; one clock; all state changes on rising clk50M
bt  input  3  raw buttons, active-low: bt[2]=guess too high, bt[1]=guess too low, bt[0]=correct/start
ssd3, ssd2, ssd1, ssd0  output  7 each  active-low segments {g..a}, registered
led  output  10  status LEDs, registered
guess  output  7  current guess, binary
guesses  output  4  responses given so far
state  output  2  FSM state, for verification

Behaviour:
- Reset: state=IDLE, lo=0, hi=MAX_VAL, guesses=0, blink counter 0; all ssd=7'b1111111, led=0. Reset mid-game aborts to these values on the same edge.
- Button front end, per bit: 2-flop synchronizer, then press = prev_sync & ~sync (falling edge). Presses are accepted 3 clocks after bt falls. Holding a button gives one press.
- If more than one press occurs in the same cycle, ignore all of them.
- guess = (lo+hi)>>1, 8-bit sum, combinational from registered lo/hi. guess is valid from the same edge on which lo/hi update.
- IDLE: all displays blank, led=0. A bt[0] press moves to GUESS. Other presses are ignored.
- GUESS:
  - ssd3 shows the guesses digit, ssd2 is blank, ssd1/ssd0 show guess tens/units; leading zero is shown.
  - too-high press: if guess==lo, go to CHEAT; else hi<=guess-1. guesses+1 in both cases.
  - too-low press: if guess==hi, go to CHEAT; else lo<=guess+1. guesses+1 in both cases.
  - correct press: guesses+1, go to WIN.
  - guesses saturates at 15. The displayed digit is min(guesses,9).
- WIN:
  - Display is as in GUESS, frozen (lo/hi/guesses held). It blinks: blank vs shown, toggling every BLINK_DIV cycles, starting shown. led=10'h3FF.
  - All buttons are ignored; only reset exits.
- CHEAT: ssd3..ssd1 show "E","r","r" (7'b0000110, 7'b0101111, 7'b0101111), ssd0 blank, led=10'b1010101010. Only reset exits.
- Outputs are registered: the display and led reflect a state change one clock after the state register updates.
- Binary search needs at most 7 guesses for MAX_VAL=99; a consistent player never reaches CHEAT.

Decomposition:
- Package p2_pkg:
  - state encoding: IDLE=2'd0, GUESS=2'd1, WIN=2'd2, CHEAT=2'd3
  - segment constants: SEG_BLANK, SEG_E, SEG_R
  - default MAX_VAL
- Sub-module button_edge: synchronizer plus falling-edge detect, one instance per bt bit.
- Digits: reuse the existing binaryToBCD and bcdSevenSegment blocks.

Test Plan:
- Reset, then bt[0] press -> state=GUESS, guess=49, guesses=0, ssd1/ssd0 display "4","9".
- Secret 37, responses high, low, low, high, high, correct -> guesses shown 49,24,36,42,39,37; WIN with guesses=6, led=3FF, display blinks with period 2*BLINK_DIV.
- Secret 99, always too-low -> guesses 49,74,87,93,96,98,99; correct gives guesses=7. Secret 0, always too-high -> guesses 49,24,11,5,2,0.
- At guess 0 (lo=0), press too-high -> CHEAT, display "Err ", led=2AA, guesses=6; further presses are ignored.
- bt[2] and bt[1] fall on the same cycle -> no change to lo/hi/guesses. A button held low for 100 cycles -> exactly one update.
- Assert reset in the middle of the 3rd guess -> next edge gives IDLE, blank display, guesses=0. A bt[0] press then gives guess=49 again.

Source files
------------

// File: rtl/p2_pkg.sv
// Shared types, constants and digit helpers for the reverse number-guessing game.
package p2_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGuess = 2'd1,
        StWin   = 2'd2,
        StCheat = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_MAX_VAL = 99;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] units_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer for an active-low button, pulsing press on its falling edge.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = prev & ~sync2;

endmodule

// File: rtl/p2_guesser.sv
// Board-side binary-search guesser: narrows [lo,hi] from player answers and flags cheating.
module p2_guesser
    import p2_pkg::*;
#(
    parameter int unsigned MAX_VAL   = DEFAULT_MAX_VAL,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic [2:0] bt,
    output logic [6:0] ssd3,
    output logic [6:0] ssd2,
    output logic [6:0] ssd1,
    output logic [6:0] ssd0,
    output logic [9:0] led,
    output logic [6:0] guess,
    output logic [3:0] guesses,
    output logic [1:0] state
);

    logic [2:0]  press;
    state_t      state_q;
    logic [6:0]  lo_q, hi_q;
    logic [3:0]  guesses_q;
    logic [31:0] blink_cnt_q;
    logic        blank_q;
    logic [3:0]  count_digit;
    logic [3:0]  guesses_inc;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_edge u_edge (
            .clk   (clk50M),
            .reset (reset),
            .btn   (bt[i]),
            .press (press[i])
        );
    end

    assign guess       = 7'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    assign count_digit = (guesses_q > 4'd9) ? 4'd9 : guesses_q;
    assign guesses_inc = (guesses_q == 4'd15) ? guesses_q : guesses_q + 4'd1;
    assign guesses     = guesses_q;
    assign state       = state_q;

    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q     <= StIdle;
            lo_q        <= 7'd0;
            hi_q        <= 7'(MAX_VAL);
            guesses_q   <= 4'd0;
            blink_cnt_q <= 32'd0;
            blank_q     <= 1'b0;
            ssd3        <= SEG_BLANK;
            ssd2        <= SEG_BLANK;
            ssd1        <= SEG_BLANK;
            ssd0        <= SEG_BLANK;
            led         <= 10'd0;
        end else begin
            // Simultaneous presses are ambiguous and therefore dropped entirely.
            unique case (state_q)
                StIdle: begin
                    if (press == 3'b001) state_q <= StGuess;
                end
                StGuess: begin
                    case (press)
                        3'b100: begin
                            guesses_q <= guesses_inc;
                            if (guess == lo_q) state_q <= StCheat;
                            else               hi_q    <= guess - 7'd1;
                        end
                        3'b010: begin
                            guesses_q <= guesses_inc;
                            if (guess == hi_q) state_q <= StCheat;
                            else               lo_q    <= guess + 7'd1;
                        end
                        3'b001: begin
                            guesses_q <= guesses_inc;
                            state_q   <= StWin;
                        end
                        default: ;
                    endcase
                end
                StWin: begin
                    if (blink_cnt_q == BLINK_DIV - 1) begin
                        blink_cnt_q <= 32'd0;
                        blank_q     <= ~blank_q;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + 32'd1;
                    end
                end
                StCheat: ;
                default: ;
            endcase

            unique case (state_q)
                StGuess, StWin: begin
                    if (state_q == StWin && blank_q) begin
                        ssd3 <= SEG_BLANK;
                        ssd1 <= SEG_BLANK;
                        ssd0 <= SEG_BLANK;
                    end else begin
                        ssd3 <= seg_digit(count_digit);
                        ssd1 <= seg_digit(tens_of(guess));
                        ssd0 <= seg_digit(units_of(guess));
                    end
                    ssd2 <= SEG_BLANK;
                    led  <= (state_q == StWin) ? 10'h3FF : 10'd0;
                end
                StCheat: begin
                    ssd3 <= SEG_E;
                    ssd2 <= SEG_R;
                    ssd1 <= SEG_R;
                    ssd0 <= SEG_BLANK;
                    led  <= 10'b1010101010;
                end
                default: begin
                    ssd3 <= SEG_BLANK;
                    ssd2 <= SEG_BLANK;
                    ssd1 <= SEG_BLANK;
                    ssd0 <= SEG_BLANK;
                    led  <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2_guesser.sv
// Directed bench for p2_guesser: binary-search games, cheat detection, button edge cases, reset.
module tb_p2_guesser;

    logic       clk50M = 1'b0;
    logic       reset;
    logic [2:0] bt;
    logic [6:0] ssd3, ssd2, ssd1, ssd0;
    logic [9:0] led;
    logic [6:0] guess;
    logic [3:0] guesses;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] BL = 7'h7F;

    p2_guesser #(.MAX_VAL(99), .BLINK_DIV(4)) dut (
        .clk50M  (clk50M),
        .reset   (reset),
        .bt      (bt),
        .ssd3    (ssd3),
        .ssd2    (ssd2),
        .ssd1    (ssd1),
        .ssd0    (ssd0),
        .led     (led),
        .guess   (guess),
        .guesses (guesses),
        .state   (state)
    );

    always #5 clk50M = ~clk50M;

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press one button: action lands on the 3rd edge, then release and let outputs settle.
    task automatic press(input int b);
        bt[b] = 1'b0;
        repeat (3) tick();
        bt = 3'b111;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_guess(input string tag, input int g, input int n);
        check({tag, " guess"}, 32'(guess), 32'(g));
        check({tag, " guesses"}, 32'(guesses), 32'(n));
    endtask

    task automatic check_disp(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        check({tag, " ssd3"}, 32'(ssd3), 32'(d3));
        check({tag, " ssd2"}, 32'(ssd2), 32'(d2));
        check({tag, " ssd1"}, 32'(ssd1), 32'(d1));
        check({tag, " ssd0"}, 32'(ssd0), 32'(d0));
    endtask

    initial begin
        bt    = 3'b111;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst state", 32'(state), 0);
        check("rst led", 32'(led), 0);
        check_disp("rst", BL, BL, BL, BL);
        check_guess("rst", 49, 0);

        // Non-start presses in IDLE are ignored
        press(2);
        check("idle ignore", 32'(state), 0);

        // Secret 37
        press(0);
        check("start state", 32'(state), 1);
        check_guess("start", 49, 0);
        check_disp("start", seg[0], BL, seg[4], seg[9]);
        press(2);
        check_guess("s37 1", 24, 1);
        check_disp("s37 1", seg[1], BL, seg[2], seg[4]);
        press(1);
        check_guess("s37 2", 36, 2);
        press(1);
        check_guess("s37 3", 42, 3);
        press(2);
        check_guess("s37 4", 39, 4);
        press(2);
        check_guess("s37 5", 37, 5);
        check_disp("s37 5", seg[5], BL, seg[3], seg[7]);
        press(0);
        check("win state", 32'(state), 2);
        check_guess("win", 37, 6);
        check("win led", 32'(led), 32'h3FF);
        check_disp("win shown", seg[6], BL, seg[3], seg[7]);
        tick();
        check_disp("win blank", BL, BL, BL, BL);
        check("win led blank", 32'(led), 32'h3FF);
        repeat (3) tick();
        check_disp("win blank end", BL, BL, BL, BL);
        tick();
        check_disp("win shown again", seg[6], BL, seg[3], seg[7]);
        press(2);
        press(0);
        check("win hold state", 32'(state), 2);
        check_guess("win hold", 37, 6);

        // Secret 99, always too-low
        do_reset();
        press(0);
        press(1); check_guess("s99 1", 74, 1);
        press(1); check_guess("s99 2", 87, 2);
        press(1); check_guess("s99 3", 93, 3);
        press(1); check_guess("s99 4", 96, 4);
        press(1); check_guess("s99 5", 98, 5);
        press(1); check_guess("s99 6", 99, 6);
        check_disp("s99 6", seg[6], BL, seg[9], seg[9]);
        press(0);
        check("s99 win", 32'(state), 2);
        check("s99 guesses", 32'(guesses), 7);

        // Secret 0, always too-high, then cheat
        do_reset();
        press(0);
        press(2); check_guess("s0 1", 24, 1);
        press(2); check_guess("s0 2", 11, 2);
        press(2); check_guess("s0 3", 5, 3);
        press(2); check_guess("s0 4", 2, 4);
        press(2); check_guess("s0 5", 0, 5);
        check_disp("s0 5", seg[5], BL, seg[0], seg[0]);
        press(2);
        check("cheat state", 32'(state), 3);
        check("cheat guesses", 32'(guesses), 6);
        check("cheat led", 32'(led), 32'h2AA);
        check_disp("cheat", 7'h06, 7'h2F, 7'h2F, BL);
        press(1);
        press(0);
        check("cheat hold state", 32'(state), 3);
        check("cheat hold guesses", 32'(guesses), 6);

        // Simultaneous presses are dropped; a long hold counts once
        do_reset();
        press(0);
        bt = 3'b001;
        repeat (3) tick();
        bt = 3'b111;
        repeat (4) tick();
        check_guess("dual", 49, 0);
        bt[1] = 1'b0;
        repeat (100) tick();
        bt = 3'b111;
        repeat (4) tick();
        check_guess("hold", 74, 1);

        // Reset during the third guess
        do_reset();
        press(0);
        press(2);
        press(1);
        check_guess("mid pre", 36, 2);
        reset = 1'b1;
        tick();
        check("mid state", 32'(state), 0);
        check("mid guesses", 32'(guesses), 0);
        check("mid led", 32'(led), 0);
        check_disp("mid", BL, BL, BL, BL);
        reset = 1'b0;
        press(0);
        check("mid restart state", 32'(state), 1);
        check_guess("mid restart", 49, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
